// File: rtl/rv_ctrl_pkg.sv
// Shared run-control types and constants for the RV32I core sequencer.
// The testbench reuses END_INSTR so both agree on the end-of-program word.
package rv_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STEP = 2'd2,
      HALT = 2'd3
   } run_state_t;

   typedef enum logic [2:0] {
      CAUSE_NONE    = 3'd0,
      CAUSE_HALTREQ = 3'd1,
      CAUSE_BREAK   = 3'd2,
      CAUSE_END     = 3'd3,
      CAUSE_STEP    = 3'd4
   } halt_cause_t;

   // jal x0,0 : the program parks itself in a self-loop when it is done
   localparam logic [31:0] END_INSTR = 32'h0000006F;

endpackage

// File: rtl/run_ctrl_edge_detect.sv
// One-bit rising-edge detector with synchronous active-high reset.
// The delayed copy is updated every cycle so a held level fires only once.
module edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise
);

   logic d_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         d_q <= 1'b0;
      end else begin
         d_q <= d;
      end
   end

   assign rise = d & ~d_q;

endmodule

// File: rtl/run_ctrl.sv
// Run-control sequencer: gates the single-cycle core with a zero-latency
// execute enable and tracks why and when execution stopped.
module run_ctrl #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 32,
   parameter logic [DATA_WIDTH-1:0] END_INSTR = DATA_WIDTH'(rv_ctrl_pkg::END_INSTR)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  trigger,
   input  logic                  step,
   input  logic                  halt_req,
   input  logic                  bp_en,
   input  logic [ADDR_WIDTH-1:0] bp_addr,
   input  logic [ADDR_WIDTH-1:0] PC,
   input  logic [DATA_WIDTH-1:0] Instr,
   output logic                  core_en,
   output logic                  running,
   output logic                  halted,
   output logic [2:0]            halt_cause,
   output logic [CNT_WIDTH-1:0]  cycle_count,
   output logic [CNT_WIDTH-1:0]  instr_retired
);

   import rv_ctrl_pkg::*;

   run_state_t  state_q, state_d;
   halt_cause_t cause_q, cause_d;
   logic        skip_bp_q, skip_bp_d;
   logic        trig_rise, step_rise;
   logic        is_end, bp_hit;

   edge_detect u_trig_edge (
      .clk  (clk),
      .rst  (rst),
      .d    (trigger),
      .rise (trig_rise)
   );

   edge_detect u_step_edge (
      .clk  (clk),
      .rst  (rst),
      .d    (step),
      .rise (step_rise)
   );

   assign is_end = (Instr == END_INSTR);
   assign bp_hit = bp_en && (PC == bp_addr) && !skip_bp_q;

   // Stop conditions block the instruction in the very cycle they are seen,
   // so core_en is decoded straight from state and inputs.
   always_comb begin
      state_d   = state_q;
      cause_d   = cause_q;
      skip_bp_d = skip_bp_q;
      core_en   = 1'b0;

      unique case (state_q)
         IDLE, HALT: begin
            if (!(state_q == HALT && cause_q == CAUSE_END)) begin
               if (step_rise) begin
                  state_d = STEP;
               end else if (trig_rise) begin
                  state_d   = RUN;
                  skip_bp_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (halt_req) begin
               state_d = HALT;
               cause_d = CAUSE_HALTREQ;
            end else if (is_end) begin
               state_d = HALT;
               cause_d = CAUSE_END;
            end else if (bp_hit) begin
               state_d = HALT;
               cause_d = CAUSE_BREAK;
            end else begin
               core_en   = 1'b1;
               skip_bp_d = 1'b0;
            end
         end
         STEP: begin
            state_d = HALT;
            if (is_end) begin
               cause_d = CAUSE_END;
            end else begin
               core_en = 1'b1;
               cause_d = CAUSE_STEP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (rst) begin
         core_en = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cause_q    <= CAUSE_NONE;
         skip_bp_q  <= 1'b0;
         running    <= 1'b0;
         halted     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cause_q    <= cause_d;
         skip_bp_q  <= skip_bp_d;
         running    <= (state_d == RUN);
         halted     <= (state_d == HALT);
      end
   end

   assign halt_cause = cause_q;

   // Both counters track enabled cycles; they diverge only in a pipelined core.
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_count   <= '0;
         instr_retired <= '0;
      end else if (core_en) begin
         cycle_count   <= cycle_count + 1'b1;
         instr_retired <= instr_retired + 1'b1;
      end
   end

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: scenario tasks plus a randomized run,
// all checked against a behavioural model of the run-control rules.
module tb_run_ctrl;

   localparam logic [31:0] ADDI = 32'h00100093;
   localparam logic [31:0] ENDW = rv_ctrl_pkg::END_INSTR;

   logic        clk = 1'b0;
   logic        rst, trigger, step, halt_req, bp_en;
   logic [31:0] bp_addr, PC, Instr;
   logic        core_en, running, halted;
   logic [2:0]  halt_cause;
   logic [31:0] cycle_count, instr_retired;
   logic        core_en_w, running_w, halted_w;
   logic [2:0]  halt_cause_w;
   logic [3:0]  cycle_count_w, instr_retired_w;

   int checks = 0;
   int errors = 0;

   logic [31:0] prog [0:31];
   logic [31:0] pc;

   // Behavioural model: mode 0 idle, 1 running, 2 stepping, 3 halted
   int          m_mode;
   int          m_cause;
   bit          m_skip;
   bit          m_tq, m_sq;
   longint      m_cnt;
   int          en_diff, en_obs;

   always #5 clk = ~clk;

   run_ctrl dut (
      .clk (clk), .rst (rst), .trigger (trigger), .step (step),
      .halt_req (halt_req), .bp_en (bp_en), .bp_addr (bp_addr),
      .PC (PC), .Instr (Instr), .core_en (core_en), .running (running),
      .halted (halted), .halt_cause (halt_cause),
      .cycle_count (cycle_count), .instr_retired (instr_retired)
   );

   run_ctrl #(.CNT_WIDTH(4)) dut_w (
      .clk (clk), .rst (rst), .trigger (trigger), .step (step),
      .halt_req (halt_req), .bp_en (bp_en), .bp_addr (bp_addr),
      .PC (PC), .Instr (Instr), .core_en (core_en_w), .running (running_w),
      .halted (halted_w), .halt_cause (halt_cause_w),
      .cycle_count (cycle_count_w), .instr_retired (instr_retired_w)
   );

   function automatic bit model_enable();
      if (rst) return 1'b0;
      if (m_mode == 1)
         return !halt_req && (Instr != ENDW) && !(bp_en && PC == bp_addr && !m_skip);
      if (m_mode == 2) return Instr != ENDW;
      return 1'b0;
   endfunction

   task automatic model_update(input bit en);
      bit tr, sr;
      tr = trigger && !m_tq;
      sr = step && !m_sq;
      if (rst) begin
         m_mode = 0; m_cause = 0; m_skip = 0; m_cnt = 0;
         m_tq = 0; m_sq = 0; pc = 0;
         return;
      end
      if (m_mode == 0 || m_mode == 3) begin
         if (!(m_mode == 3 && m_cause == 3)) begin
            if (sr) m_mode = 2;
            else if (tr) begin m_mode = 1; m_skip = 1; end
         end
      end else if (m_mode == 1) begin
         if (halt_req) begin m_mode = 3; m_cause = 1; end
         else if (Instr == ENDW) begin m_mode = 3; m_cause = 3; end
         else if (bp_en && PC == bp_addr && !m_skip) begin m_mode = 3; m_cause = 2; end
         else m_skip = 0;
      end else begin
         m_mode = 3;
         m_cause = (Instr == ENDW) ? 3 : 4;
      end
      if (en) begin
         m_cnt = m_cnt + 1;
         pc = pc + 4;
      end
      m_tq = trigger;
      m_sq = step;
   endtask

   task automatic tick();
      bit exp_en;
      PC    = pc;
      Instr = prog[pc[6:2]];
      #1;
      exp_en = model_enable();
      if (core_en !== exp_en || core_en_w !== exp_en) en_diff++;
      if (core_en === 1'b1) en_obs++;
      @(posedge clk);
      model_update(exp_en);
      #1;
      PC    = pc;
      Instr = prog[pc[6:2]];
   endtask

   task automatic load_prog(input int end_idx);
      for (int i = 0; i < 32; i++) prog[i] = (i == end_idx) ? ENDW : ADDI;
   endtask

   task automatic do_reset();
      rst = 1'b1; trigger = 1'b0; step = 1'b0; halt_req = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic pulse_trigger();
      trigger = 1'b1; tick(); trigger = 1'b0;
   endtask

   task automatic run_until_halt(input string tag);
      int budget;
      budget = 0;
      while (m_mode != 3 && budget < 60) begin tick(); budget++; end
      checks++;
      if (budget >= 60) begin
         errors++; $display("[TB] FAIL %s timeout: model never halted within 60 cycles", tag);
      end
   endtask

   task automatic test_reset();
      bp_en = 1'b0; bp_addr = '0; pc = 0; load_prog(-1);
      en_diff = 0;
      do_reset();
      checks++;
      if ({running, halted, halt_cause} !== 5'b0) begin
         errors++; $display("[TB] FAIL reset_flags got %b%b%0d need 000", running, halted, halt_cause);
      end
      checks++;
      if (cycle_count !== 0 || instr_retired !== 0 || cycle_count_w !== 0) begin
         errors++; $display("[TB] FAIL reset_counts got %0d/%0d need 0", cycle_count, instr_retired);
      end
      checks++;
      if (en_diff !== 0) begin
         errors++; $display("[TB] FAIL reset_core_en mismatching cycles %0d need 0", en_diff);
      end
   endtask

   task automatic test_end_program();
      load_prog(3); do_reset();
      en_diff = 0; en_obs = 0;
      pulse_trigger();
      run_until_halt("end_program");
      checks++;
      if (en_obs !== 3 || en_diff !== 0) begin
         errors++; $display("[TB] FAIL end_core_en high %0d cycles (diff %0d) need 3", en_obs, en_diff);
      end
      checks++;
      if (halted !== 1'b1 || halt_cause !== 3'd3) begin
         errors++; $display("[TB] FAIL end_cause got halted=%b cause=%0d need 1/3", halted, halt_cause);
      end
      checks++;
      if (cycle_count !== 3 || instr_retired !== 3) begin
         errors++; $display("[TB] FAIL end_counts got %0d/%0d need 3/3", cycle_count, instr_retired);
      end
   endtask

   task automatic test_breakpoint();
      load_prog(10); do_reset();
      bp_en = 1'b1; bp_addr = 32'h8; en_diff = 0;
      pulse_trigger();
      run_until_halt("breakpoint");
      checks++;
      if (halt_cause !== 3'd2 || cycle_count !== 2 || PC !== 32'h8 || core_en !== 1'b0) begin
         errors++; $display("[TB] FAIL bp_hit got cause=%0d count=%0d pc=%h en=%b need 2/2/8/0",
                            halt_cause, cycle_count, PC, core_en);
      end
      pulse_trigger();
      tick();
      checks++;
      if (cycle_count !== 3 || running !== 1'b1) begin
         errors++; $display("[TB] FAIL bp_resume got count=%0d running=%b need 3/1", cycle_count, running);
      end
      run_until_halt("bp_resume");
      checks++;
      if (halt_cause !== 3'd3 || cycle_count !== 10 || en_diff !== 0) begin
         errors++; $display("[TB] FAIL bp_to_end got cause=%0d count=%0d diff=%0d need 3/10/0",
                            halt_cause, cycle_count, en_diff);
      end
      bp_en = 1'b0;
   endtask

   task automatic test_step();
      load_prog(-1); do_reset();
      en_diff = 0;
      for (int i = 0; i < 3; i++) begin
         en_obs = 0;
         step = 1'b1; tick(); step = 1'b0; tick(); tick();
         checks++;
         if (en_obs !== 1 || halt_cause !== 3'd4 || halted !== 1'b1) begin
            errors++; $display("[TB] FAIL step_%0d got en_cycles=%0d cause=%0d halted=%b need 1/4/1",
                               i, en_obs, halt_cause, halted);
         end
      end
      checks++;
      if (instr_retired !== 3) begin
         errors++; $display("[TB] FAIL step_retired got %0d need 3", instr_retired);
      end
      step = 1'b1; trigger = 1'b1; tick(); step = 1'b0; trigger = 1'b0;
      checks++;
      if (running !== 1'b0 || halted !== 1'b0) begin
         errors++; $display("[TB] FAIL step_wins got running=%b halted=%b need 0/0", running, halted);
      end
      tick();
      checks++;
      if (halt_cause !== 3'd4 || instr_retired !== 4 || en_diff !== 0) begin
         errors++; $display("[TB] FAIL step_wins_after got cause=%0d count=%0d diff=%0d need 4/4/0",
                            halt_cause, instr_retired, en_diff);
      end
   endtask

   task automatic test_halt_req();
      load_prog(-1); do_reset();
      en_diff = 0; en_obs = 0;
      pulse_trigger();
      for (int i = 0; i < 4; i++) tick();
      halt_req = 1'b1;
      #1;
      checks++;
      if (core_en !== 1'b0) begin
         errors++; $display("[TB] FAIL halt_req_same_cycle got core_en=%b need 0", core_en);
      end
      tick();
      checks++;
      if (halt_cause !== 3'd1 || cycle_count !== 4 || en_obs !== 4) begin
         errors++; $display("[TB] FAIL halt_req got cause=%0d count=%0d need 1/4", halt_cause, cycle_count);
      end
      tick();
      halt_req = 1'b0;
      pulse_trigger(); tick();
      checks++;
      if (running !== 1'b1 || cycle_count !== 5 || en_diff !== 0) begin
         errors++; $display("[TB] FAIL halt_req_resume got running=%b count=%0d need 1/5", running, cycle_count);
      end
   endtask

   task automatic test_reset_mid_run();
      en_diff = 0;
      rst = 1'b1; tick(); rst = 1'b0;
      checks++;
      if (running !== 1'b0 || halted !== 1'b0 || halt_cause !== 3'd0 || cycle_count !== 0) begin
         errors++; $display("[TB] FAIL mid_run_reset got run=%b halt=%b cause=%0d count=%0d need 0/0/0/0",
                            running, halted, halt_cause, cycle_count);
      end
      pulse_trigger(); tick(); tick();
      checks++;
      if (cycle_count !== 2 || running !== 1'b1 || en_diff !== 0) begin
         errors++; $display("[TB] FAIL restart_count got %0d running=%b need 2/1", cycle_count, running);
      end
   endtask

   task automatic test_end_lock_and_wrap();
      load_prog(1); do_reset();
      pulse_trigger();
      run_until_halt("end_lock");
      en_obs = 0;
      pulse_trigger(); tick(); step = 1'b1; tick(); step = 1'b0; tick(); tick();
      checks++;
      if (halted !== 1'b1 || halt_cause !== 3'd3 || cycle_count !== 1 || en_obs !== 0) begin
         errors++; $display("[TB] FAIL end_lock got halted=%b cause=%0d count=%0d en=%0d need 1/3/1/0",
                            halted, halt_cause, cycle_count, en_obs);
      end
      load_prog(-1); do_reset();
      pulse_trigger();
      for (int i = 0; i < 40 && m_cnt < 17; i++) tick();
      checks++;
      if (cycle_count_w !== 4'd1 || instr_retired_w !== 4'd1 || cycle_count !== 17) begin
         errors++; $display("[TB] FAIL wrap got narrow=%0d/%0d wide=%0d need 1/1/17",
                            cycle_count_w, instr_retired_w, cycle_count);
      end
   endtask

   task automatic test_random();
      int bad;
      bad = 0;
      for (int i = 0; i < 32; i++) prog[i] = ($urandom_range(0, 9) == 0) ? ENDW : ADDI;
      do_reset();
      en_diff = 0;
      for (int n = 0; n < 600; n++) begin
         rst      = ($urandom_range(0, 79) == 0);
         trigger  = ($urandom_range(0, 3) == 0);
         step     = ($urandom_range(0, 5) == 0);
         halt_req = ($urandom_range(0, 11) == 0);
         bp_en    = $urandom_range(0, 1);
         bp_addr  = 32'($urandom_range(0, 15)) << 2;
         tick();
         checks++;
         if (running !== (m_mode == 1) || halted !== (m_mode == 3) ||
             halt_cause !== 3'(m_cause) || cycle_count !== 32'(m_cnt) ||
             instr_retired !== 32'(m_cnt) || cycle_count_w !== 4'(m_cnt)) begin
            errors++;
            $display("[TB] FAIL random_%0d got run=%b halt=%b cause=%0d count=%0d need %0b/%0b/%0d/%0d",
                     n, running, halted, halt_cause, cycle_count,
                     m_mode == 1, m_mode == 3, m_cause, m_cnt);
         end
      end
      checks++;
      if (en_diff !== 0) begin
         errors++; $display("[TB] FAIL random_core_en mismatching cycles %0d need 0", en_diff);
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; trigger = 1'b0; step = 1'b0; halt_req = 1'b0;
      bp_en = 1'b0; bp_addr = '0; PC = '0; Instr = ADDI; pc = 0;
      m_mode = 0; m_cause = 0; m_skip = 0; m_tq = 0; m_sq = 0; m_cnt = 0;
      en_diff = 0; en_obs = 0;
      @(posedge clk); #1;
      test_reset();
      test_end_program();
      test_breakpoint();
      test_step();
      test_halt_req();
      test_reset_mid_run();
      test_end_lock_and_wrap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
Run-control sequencer for the single-cycle RV32I core. It gates core execution through a per-cycle enable that qualifies the PC register, the register-file write and the data-memory write. It provides start/resume, single-step, external halt, one PC breakpoint and end-of-program detection, and keeps cycle and retired-instruction counters for the testbench and debug. It sits beside the top-level core, taking PC and Instr from the fetch path.

Parameters:
ADDR_WIDTH, 32, PC/breakpoint width
DATA_WIDTH, 32, instruction width
CNT_WIDTH, 32, width of each counter
END_INSTR, 32'h0000006F, end-of-program encoding (jal x0,0 self-loop)

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
trigger  in  1  start/resume request, rising-edge detected
step  in  1  single-step request, rising-edge detected
halt_req  in  1  external halt request, level
bp_en  in  1  breakpoint enable
bp_addr  in  ADDR_WIDTH  breakpoint PC
PC  in  ADDR_WIDTH  current fetch PC
Instr  in  DATA_WIDTH  current instruction
core_en  out  1  combinational execute-enable to the core
running  out  1  registered; state is RUN
halted  out  1  registered; state is HALT
halt_cause  out  3  registered: 0 NONE, 1 HALTREQ, 2 BREAK, 3 END, 4 STEP
cycle_count  out  CNT_WIDTH  cycles with core_en=1
instr_retired  out  CNT_WIDTH  instructions retired

Behaviour:
- Reset: state IDLE, halt_cause 0, running 0, halted 0, both counters 0, skip_bp 0, edge registers 0. core_en is 0 during the reset cycle.
- Edges: trig_rise = trigger & ~trig_q and step_rise = step & ~step_q. trig_q and step_q are registered every cycle, including while in RUN.
- States: IDLE, RUN, STEP, HALT. core_en is a pure function of state, inputs and skip_bp, with zero latency, so an instruction is blocked in the same cycle its stop condition is seen.
- IDLE/HALT: core_en = 0.
  - step_rise: go to STEP. Step wins if trig_rise occurs in the same cycle.
  - trig_rise: go to RUN and set skip_bp = 1.
  - HALT with cause END ignores both requests; only rst leaves it.
- RUN, priority order:
  - halt_req: core_en = 0, go to HALT, cause 1.
  - Instr == END_INSTR: core_en = 0, go to HALT, cause 3. The END instruction is not retired.
  - bp_en && PC == bp_addr && !skip_bp: core_en = 0, go to HALT, cause 2.
  - Otherwise core_en = 1 and state stays RUN.
  - skip_bp clears on the first RUN cycle with core_en = 1, which lets a resume execute past the breakpoint instruction.
- STEP, one cycle only:
  - Instr == END_INSTR: core_en = 0, go to HALT, cause 3.
  - Otherwise core_en = 1, go to HALT, cause 4.
  - Breakpoint and halt_req are ignored in STEP.
- Counters: cycle_count and instr_retired both increment by 1 on each cycle with core_en = 1. They stay identical in the single-cycle core; instr_retired is kept separate for the pipelined core. Both wrap modulo 2^CNT_WIDTH and are held across HALT. Only rst clears them.
- running/halted/halt_cause take the value of the next state and cause, so they are valid one cycle after the decision.
- rst in any state, mid-RUN or mid-STEP, returns to IDLE next edge with core_en = 0 in that cycle.
- halt_req held high while in HALT has no effect.
- A trig_rise while in RUN is ignored.

Decomposition:
- Shared package rv_ctrl_pkg holds:
  - the run_state_t enum (IDLE, RUN, STEP, HALT);
  - the halt_cause_t 3-bit enum;
  - the END_INSTR localparam, reused by the testbench.
- One natural sub-module: edge_detect (1-bit rising-edge detector with synchronous reset), instantiated twice for trigger and step.
- Counters stay inline.

Test Plan:
1. Reset, then trigger pulse, with Instr = ADDI for PCs 0..8 and END_INSTR at PC 12 → core_en high for exactly 3 cycles; halted = 1, halt_cause = 3, cycle_count = instr_retired = 3.
2. bp_en = 1, bp_addr = 0x8, trigger → halt with PC = 0x8, cause 2, core_en = 0 at PC 0x8, count = 2. A second trigger → the instruction at 0x8 executes and no re-break occurs on that first cycle.
3. Three step pulses from IDLE → core_en high exactly 1 cycle per pulse; halt_cause = 4 after each, instr_retired = 3. Step and trigger on the same edge → STEP taken.
4. halt_req asserted in the 5th RUN cycle → core_en = 0 that same cycle, cause 1, count = 4. Trigger after halt_req drops → running resumes.
5. rst asserted mid-RUN → next cycle state IDLE, core_en = 0, counters = 0, halt_cause = 0. A trigger then restarts with counts from 0.
6. After END halt (cause 3), trigger and step pulses → no change. Counter wrap with CNT_WIDTH = 4 over 17 enabled cycles → cycle_count = 1.
